bit_slice_transmitter: RTL and testbench
========================================

Name: bit_slice_transmitter

Overview:
- Transmit side of the bit-slice summation interface: accepts M N-bit operands from the CPU, one word per write, and stores them locally.
- On a start command, emits N consecutive M-bit slices, LSB first. Slice k carries bit k of every operand; bit j of slice k = bit k of operand j.
- Slice/valid outputs drive the data/valid input of the bit-serial summation block, with an added ready input for backpressure.

Parameters:
- M, 32, number of operands = slice width
- N, 8, operand width = number of slices per transfer

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  operand write strobe
- wr_idx  in  $clog2(M)  operand index
- wr_data  in  N  operand value
- clear  in  1  zero all stored operands
- start  in  1  begin slice transfer
- slice_ready  in  1  downstream accepts slice (tie 1 for the summation block)
- slice_vld  out  1  slice valid
- slice  out  M  current bit-slice
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse after last slice accepted
- wr_err  out  1  one-cycle pulse: rejected write

Behaviour:
- Reset (async, rst_n=0): state IDLE, operand array all 0, bit counter 0, slice 0, slice_vld 0, busy 0, done 0, wr_err 0. Release takes effect on the first clock edge with rst_n=1.
- Storage: M x N register array. slice is a register loaded from one column of the array; it is never combinationally decoded onto the port.
- FSM states:
  - IDLE:
    - wr_en with wr_idx<M and no start: writes mem[wr_idx] <= wr_data.
    - wr_en with wr_idx>=M (M not a power of 2): no write, wr_err pulse.
    - clear: zeros the whole array; clear takes priority over a same-cycle wr_en, and that wr_en is dropped without wr_err.
    - start: loads column 0 into slice, sets slice_vld=1, busy=1, bit counter=0, state SEND.
    - start and wr_en in the same cycle: start wins, write dropped, wr_err pulse.
  - SEND:
    - On each edge with slice_vld&slice_ready:
      - if counter==N-1: slice_vld<=0, busy<=0, done<=1 for one cycle, state IDLE. slice keeps its last value.
      - else: counter+1, slice <= column counter+1.
    - slice_ready=0: slice and slice_vld hold unchanged (no drop, no repeat).
    - start ignored; clear ignored.
    - wr_en rejected: array unchanged, wr_err pulse.
- Latency, slice_ready=1 throughout:
  - start sampled at edge t -> slice 0 valid in cycle t+1, slice N-1 in cycle t+N.
  - done high in cycle t+N+1; busy high cycles t+1..t+N.
  - Next start is accepted at edge t+N+1 at the earliest; done and a new start may coincide.
- Operand array is never modified by a transfer. Repeated start resends identical slices.
- Reset mid-transfer: immediate abort, no done, array zeroed.
- done and wr_err are single-cycle pulses, low otherwise.

Test Plan:
- M=4,N=4: write 3,5,9,15 to idx 0..3, start, ready=1 -> slices 4'b1111, 4'b1001, 4'b1010, 4'b1100 on 4 consecutive cycles; done next cycle. A series_adder(M=4,N=4) loopback yields result 6'd32.
- Same data, slice_ready low for 3 cycles during slice 1 -> 4'b1001 held stable with slice_vld=1; sequence and total slice count unchanged; done delayed by 3 cycles.
- During SEND: wr_en idx 2 data 0 -> wr_err pulse. Then start again in IDLE -> identical slices 1111,1001,1010,1100.
- start pulsed again mid-transfer -> ignored, exactly 4 slices. start+wr_en same IDLE cycle -> transfer starts, wr_err=1, array unchanged.
- rst_n low during slice 2 -> slice_vld, busy, slice go 0 asynchronously, no done. After release, start -> all slices 0.
- clear in IDLE after load, then start -> 4 slices of 4'b0000. M=5: wr_idx=7 -> wr_err, no write.

Source files
------------

// File: rtl/bit_slice_transmitter.sv
// Bit-slice transmitter: holds M operands of N bits, written one per cycle,
// and on start sends N M-bit slices LSB first (slice k bit j = operand j bit k).
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   i_wr_en/idx/data   operand write (IDLE only, index must be < M)
//   i_clear            zero all operands (IDLE only, beats a same-cycle write)
//   i_start            begin a transfer (IDLE only, beats a same-cycle write)
//   i_slice_ready      downstream accepts the presented slice
//   o_slice_vld/o_slice  registered slice output
//   o_busy             transfer in progress
//   o_done             one-cycle pulse after the last slice is accepted
//   o_wr_err           one-cycle pulse for a rejected write
module bit_slice_transmitter #(
  parameter int unsigned M = 32,
  parameter int unsigned N = 8,
  localparam int unsigned IDX_W = (M > 1) ? $clog2(M) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [N-1:0]     i_wr_data,
  input  logic             i_clear,
  input  logic             i_start,
  input  logic             i_slice_ready,
  output logic             o_slice_vld,
  output logic [M-1:0]     o_slice,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_wr_err
);

  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_mem [M];
  logic [CNT_W-1:0] r_cnt;
  logic [M-1:0]     r_slice;
  logic             r_vld;
  logic             r_busy;
  logic             r_done;
  logic             r_wr_err;

  logic             w_idx_ok;
  logic [CNT_W-1:0] w_col_sel;
  logic [M-1:0]     w_col;

  // Index range check is only needed when M does not fill the index space.
  if ((1 << IDX_W) == M) begin : g_idx_full
    assign w_idx_ok = 1'b1;
  end else begin : g_idx_part
    assign w_idx_ok = (32'(i_wr_idx) < M);
  end

  // Column to load next: column 0 on start, following column while sending.
  assign w_col_sel = (r_state == S_SEND) ? (r_cnt + CNT_W'(1)) : '0;

  // Gather bit w_col_sel of every operand into one slice.
  always_comb begin
    w_col = '0;
    for (int j = 0; j < int'(M); j++) begin
      w_col[j] = r_mem[j][w_col_sel];
    end
  end

  // Transfer FSM, operand storage and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_slice  <= '0;
      r_vld    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wr_err <= 1'b0;
      for (int j = 0; j < int'(M); j++) begin
        r_mem[j] <= '0;
      end
    end else begin
      r_done   <= 1'b0;
      r_wr_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_clear) begin
            for (int j = 0; j < int'(M); j++) begin
              r_mem[j] <= '0;
            end
          end else if (i_wr_en && !i_start && w_idx_ok) begin
            r_mem[i_wr_idx] <= i_wr_data;
          end
          // A write dropped by clear is silent; one lost to start or a bad index is flagged.
          r_wr_err <= i_wr_en & ~i_clear & (i_start | ~w_idx_ok);
          if (i_start) begin
            r_slice <= i_clear ? '0 : w_col;
            r_vld   <= 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          r_wr_err <= i_wr_en;
          if (r_vld && i_slice_ready) begin
            if (r_cnt == CNT_W'(N - 1)) begin
              // Last slice accepted; o_slice keeps its final value.
              r_vld   <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_cnt   <= r_cnt + CNT_W'(1);
              r_slice <= w_col;
            end
          end
        end
      endcase
    end
  end

  assign o_slice_vld = r_vld;
  assign o_slice     = r_slice;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_wr_err    = r_wr_err;

endmodule

// File: tb/tb_bit_slice_transmitter.sv
// Scoreboarded bench for bit_slice_transmitter (M=4,N=4 main instance, M=5 index check instance).
module tb_bit_slice_transmitter;

  localparam int unsigned M = 4;
  localparam int unsigned N = 4;

  logic       clk;
  logic       rst_n;
  logic       i_wr_en;
  logic [1:0] i_wr_idx;
  logic [3:0] i_wr_data;
  logic       i_clear;
  logic       i_start;
  logic       i_slice_ready;
  logic       o_slice_vld;
  logic [3:0] o_slice;
  logic       o_busy;
  logic       o_done;
  logic       o_wr_err;

  logic       u5_wr_en;
  logic [2:0] u5_wr_idx;
  logic [3:0] u5_wr_data;
  logic       u5_start;
  logic       u5_vld;
  logic [4:0] u5_slice;
  logic       u5_busy;
  logic       u5_done;
  logic       u5_wr_err;

  bit_slice_transmitter #(.M(M), .N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_wr_en(i_wr_en), .i_wr_idx(i_wr_idx), .i_wr_data(i_wr_data),
    .i_clear(i_clear), .i_start(i_start), .i_slice_ready(i_slice_ready),
    .o_slice_vld(o_slice_vld), .o_slice(o_slice), .o_busy(o_busy),
    .o_done(o_done), .o_wr_err(o_wr_err)
  );

  bit_slice_transmitter #(.M(5), .N(4)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .i_wr_en(u5_wr_en), .i_wr_idx(u5_wr_idx), .i_wr_data(u5_wr_data),
    .i_clear(1'b0), .i_start(u5_start), .i_slice_ready(1'b1),
    .o_slice_vld(u5_vld), .o_slice(u5_slice), .o_busy(u5_busy),
    .o_done(u5_done), .o_wr_err(u5_wr_err)
  );

  typedef struct {
    logic [3:0] data;
    logic       last;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   e;
  int     n_chk  = 0;
  int     n_fail = 0;
  logic   err_next = 1'b0;
  logic   err_pend = 1'b0;
  logic   done_pend = 1'b0;
  logic   stall_prev = 1'b0;
  logic [3:0] held = '0;
  time    t_start;
  time    t_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_xfer(input logic [3:0] s0, input logic [3:0] s1,
                           input logic [3:0] s2, input logic [3:0] s3);
    sb_q.push_back('{data: s0, last: 1'b0});
    sb_q.push_back('{data: s1, last: 1'b0});
    sb_q.push_back('{data: s2, last: 1'b0});
    sb_q.push_back('{data: s3, last: 1'b1});
  endtask

  task automatic write_op(input logic [1:0] idx, input logic [3:0] data);
    i_wr_en = 1'b1; i_wr_idx = idx; i_wr_data = data;
    cyc();
    i_wr_en = 1'b0;
  endtask

  task automatic load_ref();
    write_op(2'd0, 4'd3);
    write_op(2'd1, 4'd5);
    write_op(2'd2, 4'd9);
    write_op(2'd3, 4'd15);
  endtask

  task automatic do_start();
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    t_start = $time;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!o_done && k < 40) begin
      cyc();
      k++;
    end
    t_done = $time;
    if (!o_done) begin
      n_chk++; n_fail++;
      $display("FAIL %s: done not seen within 40 cycles", name);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted slice and tracks done/wr_err/hold expectations.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_vld", 32'(o_slice_vld), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_slice", 32'(o_slice), 32'd0);
      sb_q.delete();
      done_pend  = 1'b0;
      err_pend   = 1'b0;
      stall_prev = 1'b0;
    end else begin
      check("done", 32'(o_done), 32'(done_pend));
      check("wr_err", 32'(o_wr_err), 32'(err_pend));
      if (stall_prev) begin
        check("hold_vld", 32'(o_slice_vld), 32'd1);
        check("hold_slice", 32'(o_slice), 32'(held));
      end
      done_pend = 1'b0;
      if (o_slice_vld && i_slice_ready) begin
        if (sb_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL slice: unexpected slice %0b", o_slice);
        end else begin
          e = sb_q.pop_front();
          check("slice", 32'(o_slice), 32'(e.data));
          done_pend = e.last;
        end
      end
      stall_prev = o_slice_vld && !i_slice_ready;
      held       = o_slice;
      err_pend   = err_next;
    end
  end

  initial begin
    rst_n = 1'b0;
    i_wr_en = 1'b0; i_wr_idx = '0; i_wr_data = '0;
    i_clear = 1'b0; i_start = 1'b0; i_slice_ready = 1'b1;
    u5_wr_en = 1'b0; u5_wr_idx = '0; u5_wr_data = '0; u5_start = 1'b0;
    cyc();
    check("reset_done", 32'(o_done), 32'd0);
    check("reset_wr_err", 32'(o_wr_err), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Basic transfer and latency.
    load_ref();
    push_xfer(4'b1111, 4'b1001, 4'b1010, 4'b1100);
    do_start();
    check("busy_after_start", 32'(o_busy), 32'd1);
    wait_done("basic");
    check("latency_basic", 32'((t_done - t_start) / 10), 32'd4);
    check("busy_after_done", 32'(o_busy), 32'd0);
    check("slice_kept", 32'(o_slice), 32'(4'b1100));

    // Backpressure for three cycles on slice 1.
    push_xfer(4'b1111, 4'b1001, 4'b1010, 4'b1100);
    do_start();
    cyc();
    i_slice_ready = 1'b0;
    repeat (3) cyc();
    i_slice_ready = 1'b1;
    wait_done("stall");
    check("latency_stall", 32'((t_done - t_start) / 10), 32'd7);

    // Write and start during SEND are rejected/ignored.
    push_xfer(4'b1111, 4'b1001, 4'b1010, 4'b1100);
    do_start();
    i_wr_en = 1'b1; i_wr_idx = 2'd2; i_wr_data = 4'd0; err_next = 1'b1;
    cyc();
    i_wr_en = 1'b0; err_next = 1'b0;
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    wait_done("send_wr");
    push_xfer(4'b1111, 4'b1001, 4'b1010, 4'b1100);
    do_start();
    wait_done("resend");

    // start and wr_en together in IDLE: start wins, write dropped with error.
    push_xfer(4'b1111, 4'b1001, 4'b1010, 4'b1100);
    i_start = 1'b1; i_wr_en = 1'b1; i_wr_idx = 2'd1; i_wr_data = 4'd0; err_next = 1'b1;
    cyc();
    i_start = 1'b0; i_wr_en = 1'b0; err_next = 1'b0;
    wait_done("start_wr");
    push_xfer(4'b1111, 4'b1001, 4'b1010, 4'b1100);
    do_start();
    wait_done("after_start_wr");

    // Reset in the middle of a transfer.
    push_xfer(4'b1111, 4'b1001, 4'b1010, 4'b1100);
    do_start();
    cyc();
    cyc();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_vld", 32'(o_slice_vld), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_slice", 32'(o_slice), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    push_xfer(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    do_start();
    wait_done("after_reset");

    // clear wipes loaded operands.
    load_ref();
    i_clear = 1'b1;
    cyc();
    i_clear = 1'b0;
    push_xfer(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    do_start();
    wait_done("clear");

    // M=5: out-of-range index rejected, valid index stored.
    u5_wr_en = 1'b1; u5_wr_idx = 3'd7; u5_wr_data = 4'hF;
    cyc();
    check("m5_bad_idx_err", 32'(u5_wr_err), 32'd1);
    u5_wr_idx = 3'd4; u5_wr_data = 4'b0101;
    cyc();
    check("m5_good_idx_err", 32'(u5_wr_err), 32'd0);
    u5_wr_en = 1'b0;
    u5_start = 1'b1;
    cyc();
    u5_start = 1'b0;
    check("m5_slice0", 32'(u5_slice), 32'(5'b10000));
    cyc();
    check("m5_slice1", 32'(u5_slice), 32'(5'b00000));
    cyc();
    check("m5_slice2", 32'(u5_slice), 32'(5'b10000));
    cyc();
    check("m5_slice3", 32'(u5_slice), 32'(5'b00000));
    check("m5_vld", 32'(u5_vld), 32'd1);
    cyc();
    check("m5_done", 32'(u5_done), 32'd1);
    check("m5_busy", 32'(u5_busy), 32'd0);

    repeat (3) cyc();
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
